// File: rtl/debug_pkg.sv
// Shared defaults and sizing helpers for the debug_capture slice.
package debug_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_TS_WIDTH = 16;

  // Pointer width for a power-of-two FIFO; never below one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/debug_fifo.sv
// First-word fall-through FIFO; head is a combinational read of the RAM.
module debug_fifo
  import debug_pkg::*;
#(
  parameter int DW    = DEF_WIDTH + DEF_TS_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);
  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [PW:0]              count_q, count_d;
  logic                     push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/debug_capture.sv
// Edge-event logger: timestamps masked rise/fall events on w into a FWFT FIFO.
// Define DEBUG_DEBOUNCE_EN to route each w bit through a debounce instance.
module debug_capture
  import debug_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int TS_WIDTH = DEF_TS_WIDTH,
  localparam int PW      = ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  input  logic [WIDTH-1:0]    w,
  input  logic [WIDTH-1:0]    rise_mask,
  input  logic [WIDTH-1:0]    fall_mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic [PW:0]         count,
  output logic                overflow,
  input  logic                clear_overflow
);
  logic [WIDTH-1:0]          w_in, prev_q, hit;
  logic [TS_WIDTH-1:0]       ts_q;
  logic                      ovf_q, ovf_d;
  logic                      evt, pop, drop, full, empty;
  logic [WIDTH+TS_WIDTH-1:0] head;

`ifdef DEBUG_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce u_db (.clk(clk), .reset(reset), .sw(w[i]), .db(w_in[i]));
  end
`else
  assign w_in = w;
`endif

  assign hit  = (~prev_q & w_in & rise_mask) | (prev_q & ~w_in & fall_mask);
  assign evt  = enabled && (|hit);
  assign pop  = out_valid && out_ready;
  assign drop = evt && full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)                ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  // enabled freezes edge detection only; ts and draining keep running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (enabled) prev_q <= w_in;
      ts_q  <= ts_q + TS_WIDTH'(1);
      ovf_q <= ovf_d;
    end
  end

  debug_fifo #(.DW(WIDTH + TS_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt),
    .pop   (pop),
    .wdata ({w_in, ts_q}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign out_data  = out_valid ? head[WIDTH+TS_WIDTH-1:TS_WIDTH] : '0;
  assign out_ts    = out_valid ? head[TS_WIDTH-1:0] : '0;
  assign overflow  = ovf_q;
endmodule
